// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants and types for the exception commit controller:
// ExcCodes, CP0 register indices, vector addresses, FSM state, latch bundle.
package exc_commit_ctrl_pkg;

    localparam logic [31:0] EXC_VEC        = 32'hBFC0_0380;
    localparam logic [31:0] TLB_REFILL_VEC = 32'hBFC0_0200;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int CP0_BADVADDR = 8;
    localparam int CP0_ENTRYHI  = 10;
    localparam int CP0_STATUS   = 12;
    localparam int CP0_CAUSE    = 13;
    localparam int CP0_EPC      = 14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_REDIR
    } state_t;

    typedef struct packed {
        logic        is_exc;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  code;
        logic [31:0] badvaddr;
        logic [5:0]  hwint;
        logic [31:0] epc;
        logic        exl;
    } exc_lat_t;

    function automatic logic has_badvaddr(input logic [4:0] code);
        return (code >= EXC_TLBL) && (code <= EXC_ADES);
    endfunction

    // TLB refill vector only when not already at exception level
    function automatic logic is_refill(input logic [4:0] code,
                                       input logic       exl);
`ifdef TLB_REFILL_VEC_EN
        return ~exl && ((code == EXC_TLBL) || (code == EXC_TLBS));
`else
        return 1'b0 & exl & code[0];
`endif
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Commit-point handshake: pipeline (master) presents a committing
// instruction, the exception controller (slave) reports commit_ready.
interface exc_commit_ctrl_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        commit_exc;
    logic [4:0]  commit_code;
    logic [31:0] commit_badvaddr;
    logic        commit_eret;
    logic        commit_ready;

    modport master (
        output commit_valid, commit_pc, commit_bd, commit_exc,
        output commit_code, commit_badvaddr, commit_eret,
        input  commit_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_bd, commit_exc,
        input  commit_code, commit_badvaddr, commit_eret,
        output commit_ready
    );
endinterface

// File: rtl/exc_commit_ctrl_int_sync.sv
// int_sync: 2-flop synchronizer for asynchronous interrupt lines.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module int_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: takes exceptions/interrupts/ERET at commit, strobes CP0
// then redirects fetch. Ports: clk, rst, cmt (commit handshake, slave),
// status_in/cause_in/epc_in/hw_int (CP0 state), cp0_* (CP0 write bus),
// flush, redirect_valid/redirect_pc. Option macro: TLB_REFILL_VEC_EN.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    exc_commit_ctrl_if.slave   cmt,
    input  logic [31:0]        status_in,
    input  logic [31:0]        cause_in,
    input  logic [31:0]        epc_in,
    input  logic [5:0]         hw_int,
    output logic [31:0]        cp0_we,
    output logic [31:0]        cp0_epc,
    output logic [31:0]        cp0_badvaddr,
    output logic               cp0_exl,
    output logic [4:0]         cp0_code,
    output logic               cp0_bd,
    output logic [5:0]         cp0_hwint,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);

    state_t      state;
    exc_lat_t    lat;
    exc_lat_t    cap;
    logic [5:0]  hw_sync;
    logic        int_pend;
    logic        accept;
    logic        ready_q;
    logic [31:0] we_nxt;
    logic [31:0] lat_target;

    wire unused_bits = ^{status_in[31:16], status_in[7:2],
                         cause_in[31:10], cause_in[7:0]};

    int_sync #(.W(6)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (hw_sync)
    );

    assign int_pend = status_in[0] & ~status_in[1] &
                      (|(status_in[15:8] & {hw_sync, cause_in[9:8]}));

    assign accept = cmt.commit_valid &
                    (int_pend | cmt.commit_exc | cmt.commit_eret);

    assign cmt.commit_ready = ready_q;

    // Interrupt outranks a synchronous exception, which outranks ERET
    always_comb begin
        cap          = '0;
        cap.is_exc   = int_pend | cmt.commit_exc;
        cap.pc       = cmt.commit_pc;
        cap.bd       = cmt.commit_bd;
        cap.code     = int_pend ? EXC_INT : cmt.commit_code;
        cap.badvaddr = cmt.commit_badvaddr;
        cap.hwint    = hw_sync;
        cap.epc      = epc_in;
        cap.exl      = status_in[1];
    end

    // Nested exception (EXL already set) must not clobber EPC
    always_comb begin
        we_nxt = '0;
        we_nxt[CP0_STATUS] = 1'b1;
        if (cap.is_exc) begin
            we_nxt[CP0_CAUSE]    = 1'b1;
            we_nxt[CP0_EPC]      = ~cap.exl;
            we_nxt[CP0_BADVADDR] = has_badvaddr(cap.code);
            we_nxt[CP0_ENTRYHI]  = is_refill(cap.code, cap.exl);
        end
    end

    always_comb begin
        lat_target = lat.epc;
        if (lat.is_exc)
            lat_target = is_refill(lat.code, lat.exl) ?
                         TLB_REFILL_VEC : EXC_VEC;
    end

    // CP0 data values come straight from the latch registers
    assign cp0_epc      = lat.bd ? (lat.pc - 32'd4) : lat.pc;
    assign cp0_badvaddr = lat.badvaddr;
    assign cp0_exl      = lat.is_exc;
    assign cp0_code     = lat.code;
    assign cp0_bd       = lat.is_exc & ~lat.exl & lat.bd;
    assign cp0_hwint    = lat.hwint;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lat            <= '0;
            cp0_we         <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            ready_q        <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_WRITE;
                        lat     <= cap;
                        cp0_we  <= we_nxt;
                        flush   <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    state          <= S_REDIR;
                    cp0_we         <= '0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= lat_target;
                end
                S_REDIR: begin
                    state          <= S_IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    ready_q        <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: exceptions, delay slot, interrupt,
// ERET, nested exception, TLB-class code, reset during WRITE.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] status_in, cause_in, epc_in;
    logic [5:0]  hw_int;
    logic [31:0] cp0_we, cp0_epc, cp0_badvaddr;
    logic        cp0_exl, cp0_bd, flush, redirect_valid;
    logic [4:0]  cp0_code;
    logic [5:0]  cp0_hwint;
    logic [31:0] redirect_pc;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef TLB_REFILL_VEC_EN
    localparam logic [31:0] T_WE  = 32'h0000_7500;
    localparam logic [31:0] T_VEC = 32'hBFC0_0200;
`else
    localparam logic [31:0] T_WE  = 32'h0000_7100;
    localparam logic [31:0] T_VEC = 32'hBFC0_0380;
`endif

    exc_commit_ctrl_if cif ();

    exc_commit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cmt            (cif),
        .status_in      (status_in),
        .cause_in       (cause_in),
        .epc_in         (epc_in),
        .hw_int         (hw_int),
        .cp0_we         (cp0_we),
        .cp0_epc        (cp0_epc),
        .cp0_badvaddr   (cp0_badvaddr),
        .cp0_exl        (cp0_exl),
        .cp0_code       (cp0_code),
        .cp0_bd         (cp0_bd),
        .cp0_hwint      (cp0_hwint),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic exc, input logic eret,
                          input logic [4:0] code, input logic [31:0] pc,
                          input logic bd, input logic [31:0] bva);
        cif.commit_valid    = 1'b1;
        cif.commit_exc      = exc;
        cif.commit_eret     = eret;
        cif.commit_code     = code;
        cif.commit_pc       = pc;
        cif.commit_bd       = bd;
        cif.commit_badvaddr = bva;
    endtask

    task automatic idle_inputs();
        cif.commit_valid = 1'b0;
        cif.commit_exc   = 1'b0;
        cif.commit_eret  = 1'b0;
        cif.commit_bd    = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        status_in = '0;
        cause_in  = '0;
        epc_in    = '0;
        hw_int    = '0;
        cif.commit_pc       = '0;
        cif.commit_code     = '0;
        cif.commit_badvaddr = '0;
        idle_inputs();
        tick();
        tick();
        chk("rst_ready", {31'd0, cif.commit_ready}, 32'd1);
        chk("rst_we", cp0_we, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_epc", cp0_epc, 32'd0);
        chk("rst_exl", {31'd0, cp0_exl}, 32'd0);
        rst = 1'b0;

        // plain commit, no event
        commit(1'b0, 1'b0, 5'd0, 32'h8000_0000, 1'b0, 32'd0);
        tick();
        chk("plain_ready", {31'd0, cif.commit_ready}, 32'd1);
        chk("plain_we", cp0_we, 32'd0);
        idle_inputs();

        // AdEL at 0x80001000
        commit(1'b1, 1'b0, 5'd4, 32'h8000_1000, 1'b0, 32'h8000_1003);
        tick();
        idle_inputs();
        chk("t1_we", cp0_we, 32'h0000_7100);
        chk("t1_epc", cp0_epc, 32'h8000_1000);
        chk("t1_bva", cp0_badvaddr, 32'h8000_1003);
        chk("t1_exl", {31'd0, cp0_exl}, 32'd1);
        chk("t1_code", {27'd0, cp0_code}, 32'd4);
        chk("t1_bd", {31'd0, cp0_bd}, 32'd0);
        chk("t1_flush", {31'd0, flush}, 32'd1);
        chk("t1_ready", {31'd0, cif.commit_ready}, 32'd0);
        chk("t1_rv_n1", {31'd0, redirect_valid}, 32'd0);
        tick();
        chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t1_rpc", redirect_pc, VEC);
        chk("t1_we_n2", cp0_we, 32'd0);
        chk("t1_flush_n2", {31'd0, flush}, 32'd1);
        tick();
        chk("t1_rv_n3", {31'd0, redirect_valid}, 32'd0);
        chk("t1_ready_n3", {31'd0, cif.commit_ready}, 32'd1);
        chk("t1_flush_n3", {31'd0, flush}, 32'd0);

        // RI in delay slot, commit_valid held through WRITE
        commit(1'b1, 1'b0, 5'd10, 32'h8000_2004, 1'b1, 32'd0);
        tick();
        chk("t2_epc", cp0_epc, 32'h8000_2000);
        chk("t2_bd", {31'd0, cp0_bd}, 32'd1);
        chk("t2_we", cp0_we, 32'h0000_7000);
        chk("t2_code", {27'd0, cp0_code}, 32'd10);
        tick();
        chk("t2_rpc", redirect_pc, VEC);
        chk("t2_held_we", cp0_we, 32'd0);
        idle_inputs();
        tick();
        chk("t2_ready", {31'd0, cif.commit_ready}, 32'd1);
        tick();
        chk("t2_no_reaccept", cp0_we, 32'd0);

        // interrupt on IP4 outranks a concurrent exception
        status_in = 32'h0000_FF01;
        hw_int    = 6'b000100;
        tick();
        tick();
        tick();
        chk("t3_wait_we", cp0_we, 32'd0);
        commit(1'b1, 1'b0, 5'd4, 32'h8000_5000, 1'b0, 32'd0);
        tick();
        idle_inputs();
        hw_int    = '0;
        status_in = '0;
        chk("t3_code", {27'd0, cp0_code}, 32'd0);
        chk("t3_hwint", {26'd0, cp0_hwint}, 32'h0000_0004);
        chk("t3_we", cp0_we, 32'h0000_7000);
        chk("t3_epc", cp0_epc, 32'h8000_5000);
        tick();
        chk("t3_rpc", redirect_pc, VEC);
        tick();

        // ERET
        epc_in = 32'h8000_3000;
        commit(1'b0, 1'b1, 5'd0, 32'h8000_0100, 1'b0, 32'd0);
        tick();
        idle_inputs();
        chk("t4_we", cp0_we, 32'h0000_1000);
        chk("t4_exl", {31'd0, cp0_exl}, 32'd0);
        tick();
        chk("t4_rv", {31'd0, redirect_valid}, 32'd1);
        chk("t4_rpc", redirect_pc, 32'h8000_3000);
        tick();

        // nested Ov with EXL=1, in delay slot
        status_in = 32'h0000_0002;
        commit(1'b1, 1'b0, 5'd12, 32'h8000_4008, 1'b1, 32'd0);
        tick();
        idle_inputs();
        status_in = '0;
        chk("t5_we", cp0_we, 32'h0000_3000);
        chk("t5_bd", {31'd0, cp0_bd}, 32'd0);
        chk("t5_code", {27'd0, cp0_code}, 32'd12);
        chk("t5_exl", {31'd0, cp0_exl}, 32'd1);
        tick();
        chk("t5_rpc", redirect_pc, VEC);
        tick();

        // TLBS (refill vector only with the option enabled)
        commit(1'b1, 1'b0, 5'd3, 32'h8000_6000, 1'b0, 32'h0040_0123);
        tick();
        idle_inputs();
        chk("t6_we", cp0_we, T_WE);
        chk("t6_bva", cp0_badvaddr, 32'h0040_0123);
        tick();
        chk("t6_rpc", redirect_pc, T_VEC);
        tick();

        // reset while in WRITE
        commit(1'b1, 1'b0, 5'd4, 32'h8000_7000, 1'b0, 32'd0);
        tick();
        idle_inputs();
        chk("t7_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t7_rv", {31'd0, redirect_valid}, 32'd0);
        chk("t7_we", cp0_we, 32'd0);
        chk("t7_ready", {31'd0, cif.commit_ready}, 32'd1);
        chk("t7_flush_off", {31'd0, flush}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t7_rv_after", {31'd0, redirect_valid}, 32'd0);
        chk("t7_ready_after", {31'd0, cif.commit_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

Interface
REQ-001 SHALL: EXC_VEC, 32'hBFC00380, general exception vector.
REQ-002 SHALL: clk  in  1  clock; all state on posedge.
REQ-003 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL: commit_valid  in  1  instruction at commit point.
REQ-005 SHALL: commit_pc  in  32  PC of committing instruction.
REQ-006 SHALL: commit_bd  in  1  instruction sits in branch delay slot.
REQ-007 SHALL: commit_exc  in  1  synchronous exception flagged by pipeline.
REQ-008 SHALL: commit_code  in  5  ExcCode of synchronous exception.
REQ-009 SHALL: commit_badvaddr  in  32  faulting virtual address.
REQ-010 SHALL: commit_eret  in  1  instruction is ERET.
REQ-011 SHALL: commit_ready  out  1  block can accept a commit.
REQ-012 SHALL: status_in  in  32  current CP0 Status.
REQ-013 SHALL: cause_in  in  32  current CP0 Cause (IP1:0 used).
REQ-014 SHALL: epc_in  in  32  current CP0 EPC.
REQ-015 SHALL: hw_int  in  6  asynchronous hardware interrupt lines.
REQ-016 SHALL: cp0_we  out  32  per-register CP0 exception write strobes.
REQ-017 SHALL: cp0_epc  out  32  EPC write value.
REQ-018 SHALL: cp0_badvaddr  out  32  BadVAddr write value.
REQ-019 SHALL: cp0_exl  out  1  Status.EXL write value.
REQ-020 SHALL: cp0_code  out  5  Cause.ExcCode write value.
REQ-021 SHALL: cp0_bd  out  1  Cause.BD write value.
REQ-022 SHALL: cp0_hwint  out  6  Cause.IP7:2 write value.
REQ-023 SHALL: flush  out  1  kill all younger pipeline stages.
REQ-024 SHALL: redirect_valid / redirect_pc  out  1/32  fetch redirect pulse and target.

Function
REQ-025 SHALL: hw_int pass a 2-flop synchronizer (hw_sync); int_pend = Status[0] & ~Status[1] & |(Status[15:8] & {hw_sync, cause_in[9:8]}).
REQ-026 SHALL: FSM IDLE->WRITE->REDIR->IDLE; commit_ready=1 only in IDLE; commit_valid outside IDLE ignored.
REQ-027 SHALL: in IDLE, commit_valid & (int_pend|commit_exc|commit_eret) latches all commit fields, hw_sync, epc_in and Status[1], moves to WRITE; otherwise stays.
REQ-028 SHALL: priority interrupt (code 0, PC = commit_pc) > commit_exc > commit_eret.
REQ-029 SHALL: WRITE (1 cycle, flush=1): exception -> cp0_we[12,13,14]=1, cp0_exl=1, cp0_bd=bd, cp0_epc = bd ? pc-4 : pc (mod 2^32); cp0_we[8]=1 only for code 2..5.
REQ-030 SHALL: exception with latched EXL=1 -> cp0_we[14]=0 and cp0_bd=0; other writes unchanged.
REQ-031 SHALL: ERET in WRITE -> only cp0_we[12]=1 with cp0_exl=0; target = latched epc_in.
REQ-032 SHALL: REDIR (1 cycle): flush=1, redirect_valid=1, redirect_pc = EXC_VEC (exception) or EPC (ERET); cp0_we=0.
REQ-033 SHALL: latency accept N -> strobes N+1 -> redirect N+2 -> commit_ready N+3; cp0_we nonzero only in WRITE.

Reset
REQ-034 SHALL: rst -> IDLE, synchronizer and latches cleared, all outputs 0 except commit_ready=1, cp0_* and redirect_pc 0.
REQ-035 SHALL: rst in WRITE/REDIR aborts without strobes or redirect in the following cycle.

Configuration
REQ-036 SHALL: with TLB_REFILL_VEC_EN defined, code 2/3 with latched EXL=0 redirects to 32'hBFC00200 and also strobes cp0_we[10] (EntryHi VPN2 from cp0_badvaddr).
REQ-037 SHALL: without TLB_REFILL_VEC_EN, all exceptions use EXC_VEC and cp0_we[10] is never asserted.

Structure
REQ-038 SHALL: shared package holds ExcCode constants, CP0 register index constants (8,10,12,13,14) and vector addresses.
REQ-039 SHALL: 2-flop synchronizer is one sub-module int_sync; FSM and latches stay in exc_commit_ctrl.

Verification
REQ-040 SHALL: commit_exc, code 4, pc 0x80001000, bd=0, EXL=0 -> N+1 we[8,12,13,14], epc 0x80001000; N+2 redirect 0xBFC00380.
REQ-041 SHALL: code 10, pc 0x80002004, bd=1 -> cp0_epc 0x80002000, cp0_bd=1, we[8]=0.
REQ-042 SHALL: Status=0x0000FF01, hw_int[2] held 3 cycles, commit_valid & commit_exc -> code 0, cp0_hwint=6'b000100.
REQ-043 SHALL: commit_eret, epc_in 0x80003000 -> only we[12], cp0_exl=0, redirect 0x80003000.
REQ-044 SHALL: EXL=1, commit_exc code 12 -> we[14]=0; rst in WRITE -> no redirect, commit_ready=1 after.
